// File: rtl/period_meter_if.sv
// period_meter_if: result bus of the strobe-period meter.
//   period        - last captured period, W bits
//   period_valid  - period holds an unconsumed result
//   period_ready  - consumer accepts period when high with period_valid
//   overflow      - one-cycle timeout pulse
//   lost          - one-cycle pulse, unconsumed result overwritten
//   locked        - recent periods are all equal
// master: the meter; slave: the consumer.
interface period_meter_if #(
  parameter int unsigned W = 9
) ();
  logic [W-1:0] period;
  logic         period_valid;
  logic         period_ready;
  logic         overflow;
  logic         lost;
  logic         locked;

  modport master (
    output period, period_valid, overflow, lost, locked,
    input  period_ready
  );

  modport slave (
    input  period, period_valid, overflow, lost, locked,
    output period_ready
  );
endinterface

// File: rtl/period_meter.sv
// period_meter: measures clock cycles between successive single-cycle
// strobes on en_in and presents each measurement on a valid/ready bus.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   en_in  - strobe under measurement
//   res    - period_meter_if.master result bus (period, period_valid,
//            period_ready, overflow, lost, locked)
// Parameters: max_period (largest measurable period, >= 2),
//             lock_count (equal periods needed for lock, >= 2).
// Optional feature: define PERIOD_METER_LOCK_EN to build lock detection;
// otherwise locked is tied to 0.
module period_meter #(
  parameter int unsigned max_period = 256,
  parameter int unsigned lock_count = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_in,
  period_meter_if.master res
);

  localparam int unsigned W = $clog2(max_period + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  // Elaboration-time parameter sanity check
  if (max_period < 2 || lock_count < 2) begin : g_param_check
    $error("period_meter: max_period and lock_count must both be >= 2");
  end

  logic [0:0]   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         overflow_q, overflow_d;
  logic         lost_q, lost_d;
  logic         capture_c;

  // Next-state, counter and output-register logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    valid_d    = valid_q;
    overflow_d = 1'b0;
    lost_d     = 1'b0;
    capture_c  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_in) begin
          state_d = ARMED;
          cnt_d   = W'(1);
        end
      end
      ARMED: begin
        if (en_in) begin
          capture_c = 1'b1;
          cnt_d     = W'(1);
        end else if (cnt_q == W'(max_period)) begin
          overflow_d = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A capture always wins over a handshake; valid stays set
    if (capture_c) begin
      period_d = cnt_q;
      valid_d  = 1'b1;
      lost_d   = valid_q && !res.period_ready;
    end else if (valid_q && res.period_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      lost_q     <= lost_d;
    end
  end

  assign res.period       = period_q;
  assign res.period_valid = valid_q;
  assign res.overflow     = overflow_q;
  assign res.lost         = lost_q;

`ifdef PERIOD_METER_LOCK_EN
  localparam int unsigned MW = $clog2(lock_count);
  localparam logic [MW-1:0] MATCH_MAX = MW'(lock_count - 1);

  logic [MW-1:0] match_q, match_d;
  logic          has_prev_q, has_prev_d;
  logic          locked_q, locked_d;

  // Consecutive-equal-capture counter; the first capture after arming
  // has no predecessor to compare against
  always_comb begin
    match_d    = match_q;
    has_prev_d = has_prev_q;
    locked_d   = locked_q;

    if (capture_c) begin
      if (has_prev_q && (cnt_q == period_q)) begin
        match_d = (match_q == MATCH_MAX) ? match_q : match_q + MW'(1);
      end else begin
        match_d = '0;
      end
      has_prev_d = 1'b1;
      locked_d   = (match_d == MATCH_MAX);
    end else if (overflow_d) begin
      match_d    = '0;
      has_prev_d = 1'b0;
      locked_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q    <= '0;
      has_prev_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      match_q    <= match_d;
      has_prev_q <= has_prev_d;
      locked_q   <= locked_d;
    end
  end

  assign res.locked = locked_q;
`else
  assign res.locked = 1'b0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: self-checking bench for period_meter. A directed
// vector table, hand-written corner sequences and randomized strobe
// gaps, all checked against a timestamp-based reference model.
module tb_period_meter;

  localparam int unsigned MAXP  = 256;
  localparam int unsigned LOCKN = 4;
  localparam int unsigned W     = $clog2(MAXP + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en_in = 1'b0;

  period_meter_if #(.W(W)) bus ();

  period_meter #(.max_period(MAXP), .lock_count(LOCKN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en_in (en_in),
    .res   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: works on strobe timestamps rather than a counter
  bit          m_armed;
  longint      m_t, m_last;
  int unsigned m_period;
  bit          m_valid, m_lost, m_ovf, m_locked;
  int unsigned m_caps[$];

  function automatic void model_reset();
    m_armed  = 0;
    m_period = 0;
    m_valid  = 0;
    m_lost   = 0;
    m_ovf    = 0;
    m_locked = 0;
    m_caps.delete();
  endfunction

  function automatic void model_step(input bit en, input bit rdy);
    bit          cap;
    int unsigned r;
    cap   = 0;
    r     = 0;
    m_t++;
    m_ovf  = 0;
    m_lost = 0;
    if (m_armed) begin
      if (en) begin
        cap    = 1;
        r      = int'(m_t - m_last);
        m_last = m_t;
      end else if (m_t - m_last == longint'(MAXP)) begin
        m_ovf   = 1;
        m_armed = 0;
        m_caps.delete();
      end
    end else if (en) begin
      m_armed = 1;
      m_last  = m_t;
    end
    if (cap) begin
      m_lost   = m_valid && !rdy;
      m_period = r;
      m_valid  = 1;
      m_caps.push_back(r);
      if (m_caps.size() > LOCKN) void'(m_caps.pop_front());
`ifdef PERIOD_METER_LOCK_EN
      m_locked = (m_caps.size() == LOCKN);
      foreach (m_caps[i]) if (m_caps[i] != m_caps[0]) m_locked = 0;
`endif
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (m_ovf) m_locked = 0;
  endfunction

  task automatic check_model();
    chk("period",       32'(bus.period),       32'(m_period));
    chk("period_valid", 32'(bus.period_valid), 32'(m_valid));
    chk("overflow",     32'(bus.overflow),     32'(m_ovf));
    chk("lost",         32'(bus.lost),         32'(m_lost));
    chk("locked",       32'(bus.locked),       32'(m_locked));
  endtask

  // One clock: drive at negedge, model and compare 1 time unit after posedge
  task automatic step(input bit en, input bit rdy);
    en_in            = en;
    bus.period_ready = rdy;
    @(posedge clk);
    model_step(en, rdy);
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          en;
    bit          rdy;
    bit          v;
    int unsigned p;
    bit          l;
    bit          o;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit en, input bit rdy, input bit v,
                              input int unsigned p, input bit l, input bit o);
    vec_t r;
    r.en = en; r.rdy = rdy; r.v = v; r.p = p; r.l = l; r.o = o;
    tbl.push_back(r);
  endfunction

  int ovf_cnt;
  int unsigned gap, last_gap, reps;
  bit rdy_r;

  initial begin
    bus.period_ready = 1'b0;
    m_t    = 0;
    m_last = 0;
    model_reset();

    // Vector table: period 5, back-pressure 7 then 9, then 3,1,1
    add(1,1, 0,0,0,0);
    repeat (4) add(0,1, 0,0,0,0);
    add(1,1, 1,5,0,0);
    add(0,1, 0,5,0,0);
    repeat (5) add(0,0, 0,5,0,0);
    add(1,0, 1,7,0,0);
    repeat (8) add(0,0, 1,7,0,0);
    add(1,0, 1,9,1,0);
    add(0,0, 1,9,0,0);
    add(0,1, 0,9,0,0);
    add(1,1, 1,3,0,0);
    add(1,1, 1,1,0,0);
    add(1,1, 1,1,0,0);
    add(0,1, 0,1,0,0);

    @(negedge clk);
    do_reset();
    chk("rst_period",   32'(bus.period),       0);
    chk("rst_valid",    32'(bus.period_valid), 0);
    chk("rst_overflow", 32'(bus.overflow),     0);
    chk("rst_lost",     32'(bus.lost),         0);
    chk("rst_locked",   32'(bus.locked),       0);

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].rdy);
      chk($sformatf("vec%0d_valid", i),    32'(bus.period_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_period", i),   32'(bus.period),       tbl[i].p);
      chk($sformatf("vec%0d_lost", i),     32'(bus.lost),         32'(tbl[i].l));
      chk($sformatf("vec%0d_overflow", i), 32'(bus.overflow),     32'(tbl[i].o));
    end

    // Boundary: strobe exactly at max_period is a capture
    do_reset();
    ovf_cnt = 0;
    step(1, 1);
    for (int i = 0; i < int'(MAXP) - 1; i++) begin
      step(0, 1);
      if (bus.overflow) ovf_cnt++;
    end
    step(1, 1);
    if (bus.overflow) ovf_cnt++;
    chk("boundary_period", 32'(bus.period), MAXP);
    chk("boundary_valid",  32'(bus.period_valid), 1);
    chk("boundary_no_ovf", 32'(ovf_cnt), 0);

    // Timeout: 257 idle cycles after arming, then strobe only re-arms
    ovf_cnt = 0;
    for (int i = 0; i < int'(MAXP) + 1; i++) begin
      step(0, 1);
      if (bus.overflow) ovf_cnt++;
    end
    chk("timeout_ovf_once", 32'(ovf_cnt), 1);
    step(1, 1);
    chk("timeout_no_capture", 32'(bus.period_valid), 0);

    // Reset mid-count with a pending result
    repeat (3) step(0, 0);
    step(1, 0);
    chk("pending_valid", 32'(bus.period_valid), 1);
    repeat (2) step(0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_period",   32'(bus.period),       0);
    chk("async_rst_valid",    32'(bus.period_valid), 0);
    chk("async_rst_overflow", 32'(bus.overflow),     0);
    chk("async_rst_lost",     32'(bus.lost),         0);
    chk("async_rst_locked",   32'(bus.locked),       0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0);
    chk("post_rst_arm_only", 32'(bus.period_valid), 0);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    chk("post_rst_period", 32'(bus.period), 3);

    // Lock: periods 6,6,6,6 then 7
    do_reset();
    step(1, 1);
    for (int k = 1; k <= 4; k++) begin
      repeat (5) step(0, 1);
      step(1, 1);
      if (k == 3) chk("lock_after_3", 32'(bus.locked), 0);
    end
`ifdef PERIOD_METER_LOCK_EN
    chk("lock_after_4", 32'(bus.locked), 1);
`else
    chk("lock_after_4", 32'(bus.locked), 0);
`endif
    repeat (6) step(0, 1);
    step(1, 1);
    chk("lock_lost_on_7", 32'(bus.locked), 0);

    // Randomized strobe gaps, some repeated, with random back-pressure
    do_reset();
    last_gap = 6;
    for (int g = 0; g < 60; g++) begin
      gap  = ($urandom_range(0, 2) == 0) ? last_gap : $urandom_range(1, 280);
      if ($urandom_range(0, 5) == 0) gap = 1;
      reps = $urandom_range(1, 5);
      last_gap = gap;
      for (int r = 0; r < int'(reps); r++) begin
        for (int c = 0; c < int'(gap) - 1; c++) begin
          rdy_r = ($urandom_range(0, 3) != 0);
          step(0, rdy_r);
        end
        rdy_r = ($urandom_range(0, 3) != 0);
        step(1, rdy_r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

Strobe-period measurement block that consumes single-cycle enable strobes, such as those produced by the team's prescaler. It measures the number of clock cycles between successive strobes and presents each measurement on a valid/ready output. It flags timeouts and lost results and can optionally report frequency lock. It sits in self-check and bring-up paths, where a strobe's cadence must be verified in hardware.

## Interface
- `max_period`, default 256: largest measurable period in clock cycles, ≥ 2. Counter width `W = $clog2(max_period+1)`.
- `lock_count`, default 4: number of consecutive equal periods required for lock, ≥ 2. Used only with lock detection enabled.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en_in`  in  1: strobe under measurement, one cycle wide per event, synchronous to `clk`.
- `period`  out  W: last captured period in cycles.
- `period_valid`  out  1: `period` holds an unconsumed result.
- `period_ready`  in  1: consumer accepts `period` when high together with `period_valid`.
- `overflow`  out  1: one-cycle pulse; no strobe arrived within `max_period` cycles.
- `lost`  out  1: one-cycle pulse; an unconsumed result was overwritten.
- `locked`  out  1: the lock_count most recent periods are equal.

## Operation
- States are IDLE and ARMED. Reset enters IDLE.
- IDLE: cycle counter `cnt` is held at 0. On `en_in`, go to ARMED with `cnt` = 1 next cycle. No capture is made.
- ARMED: `cnt` increments every cycle. On `en_in`, capture `period <= cnt` and set `cnt` to 1. The state stays ARMED.
- Period definition: strobes at cycles t0 and t0+R give `period` = R. Strobes on every cycle give 1.
- Timeout: in ARMED with `cnt == max_period` and no `en_in`:
  - pulse `overflow`,
  - go to IDLE, `cnt` = 0,
  - clear `locked` and the match count.
- A strobe exactly at `cnt == max_period` is a valid capture, not an overflow.
- Output register:
  - A capture sets `period_valid`.
  - A handshake (`period_valid && period_ready`) clears it unless a capture occurs in the same cycle.
  - Capture while `period_valid && !period_ready`: the new value overwrites `period`, `period_valid` stays 1, and `lost` pulses.
  - Capture and handshake in the same cycle: the new value loads, `period_valid` stays 1, and `lost` stays 0.
- Counter arithmetic is unsigned, W bits. `cnt` never exceeds `max_period`, so it never wraps.

## Timing
- All outputs are registered.
- `period`, `period_valid`, `lost`, and `locked` update in the cycle after the capturing strobe, which is 1-cycle latency.
- `overflow` is high in the cycle after `cnt == max_period` was sampled without a strobe.
- Reset values:
  - `period` = 0, `period_valid` = 0, `overflow` = 0, `lost` = 0, `locked` = 0,
  - state = IDLE, `cnt` = 0, match count = 0.
- Reset mid-measurement discards `cnt` and any pending result immediately and asynchronously. The first strobe after reset only arms the block.
- `period_ready` is ignored while `period_valid` = 0.

## Configuration
- `PERIOD_METER_LOCK_EN` defined:
  - A match counter increments, saturating at lock_count-1, when a capture equals the previously captured value. A capture that differs resets it to 0.
  - The first capture after arming has no predecessor and sets the counter to 0.
  - `locked` = (match count == lock_count-1). It updates together with `period_valid`.
  - Overflow or reset clears both `locked` and the match count.
- `PERIOD_METER_LOCK_EN` not defined: no match logic is present and `locked` is tied to 0.

## Test plan
- Prescaler-style strobe every 5 cycles, `period_ready` = 1 → the first strobe arms, then each later strobe gives `period` = 5 with a one-cycle `period_valid` pulse and `lost` = 0.
- Strobe every cycle → `period` = 1 with `period_valid` continuously high. Strobe at exactly 256 cycles with default `max_period` → `period` = 256 and no `overflow`.
- Back-pressure: `period_ready` = 0, periods 7 then 9 → `period_valid` stays 1, `period` = 9, and `lost` pulses once. Raising `period_ready` clears `period_valid` the next cycle.
- Timeout: arm, then no strobe for 257 cycles → `overflow` pulses once, the block returns to IDLE, and the next strobe produces no capture.
- Lock (macro defined, `lock_count` = 4): periods 6,6,6,6 → `locked` rises with the fourth result. A following period 7 → `locked` = 0.
- Reset asserted mid-count with a pending result → all outputs 0 at once. After release, two strobes 3 cycles apart → `period` = 3.
